write_arbiter: RTL and testbench
================================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 The block SHALL have parameter-free ports, listed as name  direction  width  meaning:
- ACLK  in  1  sole clock, rising edge.
- ARESETn  in  1  reset, synchronous, active-high (asserted = 1).
- AWADDR_M1/M2  in  32  write address from master 1 (CPU data) / master 2 (DMA).
- AWVALID_M1/M2, AWREADY_M1/M2  in  1 each  AW handshake as seen at each master port.
- AWLEN_M1/M2  in  4  burst length minus one.
- WVALID_M1/M2, WREADY_M1/M2, WLAST_M1/M2  in  1 each  W-channel handshake and last beat.
- BVALID_M1/M2, BREADY_M1/M2  in  1 each  B-channel handshake.
- W_grant  out  2  00 = none, 01 = M1, 10 = M2.
- W_slave  out  3  1 = IM, 2 = DM, 3 = Sctrl, 4 = WDT, 5 = DRAM, 7 = default slave, 0 = none.
- cs  out  2  FSM state: IDLE = 0, ADDR = 1, DATA = 2, RESP = 3.
- len_err  out  1  one-cycle pulse on a burst-length mismatch.

Function
REQ-002 The FSM SHALL hold a single write transaction, AW then W then B, at a time.
REQ-003 IDLE: if any AWVALID is high, next state SHALL be ADDR, and the grant SHALL be latched by round-robin.
- Both requesting: the master not granted last SHALL win.
- One requesting: that master SHALL win.
REQ-004 The last-granted register SHALL update when RESP exits, to the master just served.
REQ-005 ADDR: on AWVALID & AWREADY of the granted master, the block SHALL latch that master's AWADDR and AWLEN and go to DATA; otherwise it SHALL stay in ADDR.
REQ-006 AWVALID of the non-granted master SHALL be ignored until the block returns to IDLE.
REQ-007 DATA: a 4-bit beat counter SHALL start at 0 and increment on each WVALID & WREADY of the granted master.
- On a handshake with WLAST = 1, next state SHALL be RESP and the counter SHALL clear.
REQ-008 len_err SHALL pulse high for the cycle after a granted W handshake where either:
- WLAST = 1 and counter != latched AWLEN, or
- WLAST = 0 and counter == latched AWLEN.
REQ-009 The FSM SHALL NOT be altered by len_err; only WLAST ends DATA.
REQ-010 RESP: on BVALID & BREADY of the granted master, next state SHALL be IDLE.
- W_grant SHALL read 00 from the following cycle.
REQ-011 W_grant SHALL equal the latched grant in ADDR, DATA and RESP, and 00 in IDLE.
REQ-012 W_slave address decode:
- Address bits [31:16] = 0001 -> IM; 0002 -> DM; 1000 -> Sctrl; 1001 -> WDT.
- Bits [31:24] = 20 -> DRAM.
- All other addresses, including ROM 0000_xxxx, which is read-only -> 7.
REQ-013 W_slave source by state:
- ADDR: combinational decode of the granted master's live AWADDR.
- DATA and RESP: decode of the latched address.
- IDLE: 0.
REQ-014 A burst with AWLEN = 0 SHALL be handled as a single beat with WLAST on that beat; len_err SHALL stay 0.
REQ-015 Counter wrap: the counter SHALL saturate at 15. A 16-beat burst (AWLEN = 15) SHALL complete without wrap.
REQ-016 Requests during DATA or RESP SHALL be held off; the winner SHALL be decided in IDLE only.

Reset
REQ-017 While ARESETn = 1 at a rising edge, the block SHALL load:
- cs = IDLE, W_grant = 00, W_slave = 0, len_err = 0.
- Counter = 0, latched address = 0, latched AWLEN = 0.
- Last-granted = M2, so M1 wins the first tie.
REQ-018 Reset asserted mid-transaction, in any state, SHALL abort that transaction; the block SHALL come out of reset in IDLE with no grant.

Verification
REQ-019 Tie after reset: AWVALID_M1 = AWVALID_M2 = 1, AWADDR_M1 = 0x0002_0010, AWLEN = 0.
- Expect W_grant = 01 and W_slave = 2.
- After AW, W (WLAST), B: cs sequence 0,1,2,3,0.
- Next tie: W_grant = 10.
REQ-020 4-beat DRAM burst from M2: AWADDR = 0x2000_0100, AWLEN = 3, four W handshakes with WLAST on the 4th.
- Expect W_slave = 5 throughout.
- len_err = 0.
- RESP entered the cycle after the 4th beat.
REQ-021 Early WLAST: AWLEN = 3, WLAST on beat 2.
- Expect a len_err pulse of exactly 1 cycle.
- cs = RESP next.
REQ-022 ROM write: AWADDR_M1 = 0x0000_0040 -> W_slave = 7; the transaction completes normally.
REQ-023 Mid-burst reset: ARESETn = 1 during DATA -> next cycle cs = 0, W_grant = 00, W_slave = 0.
- Then an M1/M2 tie SHALL grant M1.

Source files
------------

// File: rtl/write_arbiter.sv
// Two-master AXI write-path arbiter: round-robin grant, one AW/W/B transaction at a time,
// target-slave decode and burst-length checking on the granted master's W stream.
module write_arbiter (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [31:0] AWADDR_M1,
   input  logic [31:0] AWADDR_M2,
   input  logic        AWVALID_M1,
   input  logic        AWVALID_M2,
   input  logic        AWREADY_M1,
   input  logic        AWREADY_M2,
   input  logic [3:0]  AWLEN_M1,
   input  logic [3:0]  AWLEN_M2,
   input  logic        WVALID_M1,
   input  logic        WVALID_M2,
   input  logic        WREADY_M1,
   input  logic        WREADY_M2,
   input  logic        WLAST_M1,
   input  logic        WLAST_M2,
   input  logic        BVALID_M1,
   input  logic        BVALID_M2,
   input  logic        BREADY_M1,
   input  logic        BREADY_M2,
   output logic [1:0]  W_grant,
   output logic [2:0]  W_slave,
   output logic [1:0]  cs,
   output logic        len_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M1   = 2'b01;
   localparam logic [1:0] GRANT_M2   = 2'b10;

   localparam logic [3:0] CNT_MAX = 4'd15;

   // Index 0 = M1, index 1 = M2, so the granted master is picked with grant_q[1].
   logic [31:0] awaddr_m  [2];
   logic [3:0]  awlen_m   [2];
   logic        awvalid_m [2];
   logic        awready_m [2];
   logic        wvalid_m  [2];
   logic        wready_m  [2];
   logic        wlast_m   [2];
   logic        bvalid_m  [2];
   logic        bready_m  [2];

   assign awaddr_m[0]  = AWADDR_M1;
   assign awaddr_m[1]  = AWADDR_M2;
   assign awlen_m[0]   = AWLEN_M1;
   assign awlen_m[1]   = AWLEN_M2;
   assign awvalid_m[0] = AWVALID_M1;
   assign awvalid_m[1] = AWVALID_M2;
   assign awready_m[0] = AWREADY_M1;
   assign awready_m[1] = AWREADY_M2;
   assign wvalid_m[0]  = WVALID_M1;
   assign wvalid_m[1]  = WVALID_M2;
   assign wready_m[0]  = WREADY_M1;
   assign wready_m[1]  = WREADY_M2;
   assign wlast_m[0]   = WLAST_M1;
   assign wlast_m[1]   = WLAST_M2;
   assign bvalid_m[0]  = BVALID_M1;
   assign bvalid_m[1]  = BVALID_M2;
   assign bready_m[0]  = BREADY_M1;
   assign bready_m[1]  = BREADY_M2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_m2_q, last_m2_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        len_err_q, len_err_d;

   logic        sel;
   logic        aw_hs;
   logic        w_hs;
   logic        w_last;
   logic        b_hs;
   logic        any_aw;
   logic        both_aw;

   assign sel     = grant_q[1];
   assign aw_hs   = awvalid_m[sel] & awready_m[sel];
   assign w_hs    = wvalid_m[sel] & wready_m[sel];
   assign w_last  = wlast_m[sel];
   assign b_hs    = bvalid_m[sel] & bready_m[sel];
   assign any_aw  = AWVALID_M1 | AWVALID_M2;
   assign both_aw = AWVALID_M1 & AWVALID_M2;

   // The slave map only looks at the upper half of the address.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{AWADDR_M1[15:0], AWADDR_M2[15:0], addr_q[15:0]};

   function automatic logic [2:0] decode_slave(input logic [15:0] hi);
      logic [2:0] slv;
      slv = 3'd7;
      if (hi == 16'h0001)
         slv = 3'd1;
      else if (hi == 16'h0002)
         slv = 3'd2;
      else if (hi == 16'h1000)
         slv = 3'd3;
      else if (hi == 16'h1001)
         slv = 3'd4;
      else if (hi[15:8] == 8'h20)
         slv = 3'd5;
      return slv;
   endfunction

   // State and datapath registers
   always_ff @(posedge ACLK) begin
      if (ARESETn) begin
         state_q   <= IDLE;
         grant_q   <= GRANT_NONE;
         last_m2_q <= 1'b1;
         addr_q    <= 32'd0;
         len_q     <= 4'd0;
         cnt_q     <= 4'd0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_m2_q <= last_m2_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (any_aw)          state_d = ADDR;
         ADDR: if (aw_hs)           state_d = DATA;
         DATA: if (w_hs && w_last)  state_d = RESP;
         RESP: if (b_hs)            state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Grant, latches, beat counter and length check
   always_comb begin
      grant_d   = grant_q;
      last_m2_d = last_m2_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      len_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (both_aw)
               grant_d = last_m2_q ? GRANT_M1 : GRANT_M2;
            else if (AWVALID_M1)
               grant_d = GRANT_M1;
            else if (AWVALID_M2)
               grant_d = GRANT_M2;
         end
         ADDR: begin
            if (aw_hs) begin
               addr_d = awaddr_m[sel];
               len_d  = awlen_m[sel];
               cnt_d  = 4'd0;
            end
         end
         DATA: begin
            if (w_hs) begin
               len_err_d = w_last ? (cnt_q != len_q) : (cnt_q == len_q);
               if (w_last)
                  cnt_d = 4'd0;
               else if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (b_hs) begin
               last_m2_d = grant_q[1];
               grant_d   = GRANT_NONE;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      cs      = state_q;
      len_err = len_err_q;
      W_grant = GRANT_NONE;
      W_slave = 3'd0;
      case (state_q)
         ADDR: begin
            W_grant = grant_q;
            W_slave = decode_slave(awaddr_m[sel][31:16]);
         end
         DATA, RESP: begin
            W_grant = grant_q;
            W_slave = decode_slave(addr_q[31:16]);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_write_arbiter.sv
// Directed bench for write_arbiter: arbitration, slave decode, length checking and reset abort.
module tb_write_arbiter;

   logic        ACLK;
   logic        ARESETn;
   logic [31:0] AWADDR_M1, AWADDR_M2;
   logic        AWVALID_M1, AWVALID_M2;
   logic        AWREADY_M1, AWREADY_M2;
   logic [3:0]  AWLEN_M1, AWLEN_M2;
   logic        WVALID_M1, WVALID_M2;
   logic        WREADY_M1, WREADY_M2;
   logic        WLAST_M1, WLAST_M2;
   logic        BVALID_M1, BVALID_M2;
   logic        BREADY_M1, BREADY_M2;
   logic [1:0]  W_grant;
   logic [2:0]  W_slave;
   logic [1:0]  cs;
   logic        len_err;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   write_arbiter dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .AWADDR_M1  (AWADDR_M1),
      .AWADDR_M2  (AWADDR_M2),
      .AWVALID_M1 (AWVALID_M1),
      .AWVALID_M2 (AWVALID_M2),
      .AWREADY_M1 (AWREADY_M1),
      .AWREADY_M2 (AWREADY_M2),
      .AWLEN_M1   (AWLEN_M1),
      .AWLEN_M2   (AWLEN_M2),
      .WVALID_M1  (WVALID_M1),
      .WVALID_M2  (WVALID_M2),
      .WREADY_M1  (WREADY_M1),
      .WREADY_M2  (WREADY_M2),
      .WLAST_M1   (WLAST_M1),
      .WLAST_M2   (WLAST_M2),
      .BVALID_M1  (BVALID_M1),
      .BVALID_M2  (BVALID_M2),
      .BREADY_M1  (BREADY_M1),
      .BREADY_M2  (BREADY_M2),
      .W_grant    (W_grant),
      .W_slave    (W_slave),
      .cs         (cs),
      .len_err    (len_err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Outputs are sampled 2 time units after the rising edge.
   task automatic step();
      @(posedge ACLK);
      #2;
   endtask

   task automatic clear_inputs();
      AWVALID_M1 = 0; AWVALID_M2 = 0; AWREADY_M1 = 0; AWREADY_M2 = 0;
      WVALID_M1  = 0; WVALID_M2  = 0; WREADY_M1  = 0; WREADY_M2  = 0;
      WLAST_M1   = 0; WLAST_M2   = 0;
      BVALID_M1  = 0; BVALID_M2  = 0; BREADY_M1  = 0; BREADY_M2  = 0;
   endtask

   task automatic w_beat(input bit m2, input bit last);
      if (m2) begin
         WVALID_M2 = 1; WREADY_M2 = 1; WLAST_M2 = last;
      end else begin
         WVALID_M1 = 1; WREADY_M1 = 1; WLAST_M1 = last;
      end
      step();
      WVALID_M1 = 0; WREADY_M1 = 0; WLAST_M1 = 0;
      WVALID_M2 = 0; WREADY_M2 = 0; WLAST_M2 = 0;
   endtask

   task automatic b_resp(input bit m2);
      if (m2) begin
         BVALID_M2 = 1; BREADY_M2 = 1;
      end else begin
         BVALID_M1 = 1; BREADY_M1 = 1;
      end
      step();
      BVALID_M1 = 0; BREADY_M1 = 0; BVALID_M2 = 0; BREADY_M2 = 0;
   endtask

   initial begin
      clear_inputs();
      AWADDR_M1 = 32'd0; AWADDR_M2 = 32'd0; AWLEN_M1 = 4'd0; AWLEN_M2 = 4'd0;

      // Reset state
      ARESETn = 1;
      step();
      step();
      check_val("rst_cs", cs, 0);
      check_val("rst_grant", W_grant, 0);
      check_val("rst_slave", W_slave, 0);
      check_val("rst_len_err", len_err, 0);
      ARESETn = 0;

      // Tie after reset: M1 wins, DM target, single beat
      AWVALID_M1 = 1; AWVALID_M2 = 1;
      AWADDR_M1 = 32'h0002_0010; AWLEN_M1 = 4'd0;
      AWADDR_M2 = 32'h2000_0100; AWLEN_M2 = 4'd3;
      #1;
      check_val("t1_cs_idle", cs, 0);
      step();
      check_val("t1_cs_addr", cs, 1);
      check_val("t1_grant", W_grant, 2'b01);
      check_val("t1_slave_live", W_slave, 2);
      AWREADY_M1 = 1;
      step();
      AWVALID_M1 = 0; AWREADY_M1 = 0; AWADDR_M1 = 32'h2000_0000;
      #1;
      check_val("t1_cs_data", cs, 2);
      check_val("t1_grant_data", W_grant, 2'b01);
      check_val("t1_slave_latched", W_slave, 2);
      w_beat(0, 1);
      check_val("t1_cs_resp", cs, 3);
      check_val("t1_len_err", len_err, 0);
      b_resp(0);
      check_val("t1_cs_back_idle", cs, 0);
      check_val("t1_grant_idle", W_grant, 0);
      check_val("t1_slave_idle", W_slave, 0);

      // Second tie goes to M2: 4-beat DRAM burst
      AWVALID_M1 = 1;
      step();
      AWVALID_M1 = 0;
      #1;
      check_val("t2_grant", W_grant, 2'b10);
      check_val("t2_cs_addr", cs, 1);
      check_val("t2_slave_live", W_slave, 5);
      AWREADY_M2 = 1;
      step();
      AWVALID_M2 = 0; AWREADY_M2 = 0;
      check_val("t2_cs_data", cs, 2);
      for (int i = 0; i < 4; i++) begin
         w_beat(1, i == 3);
         check_val($sformatf("t2_beat%0d_cs", i), cs, (i == 3) ? 3 : 2);
         check_val($sformatf("t2_beat%0d_len_err", i), len_err, 0);
         check_val($sformatf("t2_beat%0d_slave", i), W_slave, 5);
      end
      b_resp(1);
      check_val("t2_cs_idle", cs, 0);

      // Early WLAST on beat 2 of a 4-beat Sctrl burst
      AWVALID_M1 = 1; AWADDR_M1 = 32'h1000_0000; AWLEN_M1 = 4'd3;
      step();
      check_val("t3_grant", W_grant, 2'b01);
      check_val("t3_slave", W_slave, 3);
      AWREADY_M1 = 1;
      step();
      AWVALID_M1 = 0; AWREADY_M1 = 0;
      w_beat(0, 0);
      check_val("t3_beat1_len_err", len_err, 0);
      w_beat(0, 1);
      check_val("t3_cs_resp", cs, 3);
      check_val("t3_len_err_pulse", len_err, 1);
      step();
      check_val("t3_len_err_gone", len_err, 0);
      check_val("t3_cs_hold_resp", cs, 3);
      b_resp(0);
      check_val("t3_cs_idle", cs, 0);

      // ROM write decodes to default slave and completes
      AWVALID_M1 = 1; AWADDR_M1 = 32'h0000_0040; AWLEN_M1 = 4'd0;
      step();
      check_val("t4_slave_rom", W_slave, 7);
      AWREADY_M1 = 1;
      step();
      AWVALID_M1 = 0; AWREADY_M1 = 0;
      check_val("t4_slave_rom_data", W_slave, 7);
      w_beat(0, 1);
      check_val("t4_cs_resp", cs, 3);
      check_val("t4_len_err", len_err, 0);
      b_resp(0);
      check_val("t4_cs_idle", cs, 0);

      // Tie after M1 served -> M2; WDT, AWLEN=1 with a 3-beat stream (late WLAST)
      AWVALID_M1 = 1; AWVALID_M2 = 1;
      AWADDR_M1 = 32'h0001_0000; AWADDR_M2 = 32'h1001_0000; AWLEN_M2 = 4'd1;
      step();
      check_val("t5_grant", W_grant, 2'b10);
      check_val("t5_slave", W_slave, 4);
      AWREADY_M2 = 1;
      step();
      AWVALID_M1 = 0; AWVALID_M2 = 0; AWREADY_M2 = 0;
      w_beat(1, 0);
      check_val("t5_beat1_len_err", len_err, 0);
      w_beat(1, 0);
      check_val("t5_beat2_len_err", len_err, 1);
      check_val("t5_beat2_cs_stays", cs, 2);
      w_beat(1, 1);
      check_val("t5_beat3_len_err", len_err, 1);
      check_val("t5_cs_resp", cs, 3);
      b_resp(1);

      // 16-beat IM burst (AWLEN=15) completes cleanly
      AWVALID_M1 = 1; AWADDR_M1 = 32'h0001_0000; AWLEN_M1 = 4'd15;
      step();
      check_val("t6_slave", W_slave, 1);
      AWREADY_M1 = 1;
      step();
      AWVALID_M1 = 0; AWREADY_M1 = 0;
      for (int i = 0; i < 16; i++) begin
         w_beat(0, i == 15);
         check_val($sformatf("t6_beat%0d_len_err", i), len_err, 0);
      end
      check_val("t6_cs_resp", cs, 3);
      b_resp(0);

      // Reset during DATA aborts; first tie afterwards goes to M1 again
      AWVALID_M1 = 1; AWADDR_M1 = 32'h0002_0000; AWLEN_M1 = 4'd3;
      step();
      AWREADY_M1 = 1;
      step();
      AWVALID_M1 = 0; AWREADY_M1 = 0;
      w_beat(0, 0);
      check_val("t7_cs_data", cs, 2);
      ARESETn = 1;
      step();
      check_val("t7_rst_cs", cs, 0);
      check_val("t7_rst_grant", W_grant, 0);
      check_val("t7_rst_slave", W_slave, 0);
      ARESETn = 0;
      AWVALID_M1 = 1; AWVALID_M2 = 1;
      step();
      check_val("t7_tie_grant", W_grant, 2'b01);
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
